// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared FSM encodings and default widths for sum_accumulator_27b
package sum_acc_pkg;
    localparam int DEF_IN_W  = 27;
    localparam int DEF_ACC_W = 34;
    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
endpackage

// File: rtl/acc_add_stage.sv
// rtl/acc_add_stage.sv - ripple ACC_W-bit adder with carry-out; ACC_SATURATE_EN clamps to all-ones
module acc_add_stage #(
    parameter int ACC_W = 34
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);
    logic [ACC_W:0]   w_c;
    logic [ACC_W-1:0] w_raw;

    assign w_c[0] = 1'b0;

    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_bit
        full_adder_cell u_fa (
            .i_a  (i_a[gi]),
            .i_b  (i_b[gi]),
            .i_ci (w_c[gi]),
            .o_s  (w_raw[gi]),
            .o_co (w_c[gi+1])
        );
    end

    assign o_carry = w_c[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, further adds carry again (or add zero), so the clamp persists.
    assign o_sum = w_c[ACC_W] ? {ACC_W{1'b1}} : w_raw;
`else
    assign o_sum = w_raw;
`endif
endmodule

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - 1-bit full-adder cell
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// File: rtl/sum_accumulator_27b.sv
// rtl/sum_accumulator_27b.sv - block accumulator of adder sums with in/out handshakes (ACC_SATURATE_EN selects saturation)
module sum_accumulator_27b
    import sum_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [IN_W-1:0]  i_in_sum,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_acc,
    output logic             o_out_ovf,
    output logic             o_busy
);
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_rem;
    logic [ACC_W-1:0] r_out_acc;
    logic             r_out_ovf;

    logic             w_beat;
    logic [ACC_W-1:0] w_addend;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_done;

    assign w_beat = i_in_valid & o_in_ready;

    always_comb begin
        w_addend = '0;
        w_addend[IN_W-1:0] = i_in_sum;
    end

    acc_add_stage #(.ACC_W(ACC_W)) u_add (
        .i_a     (r_acc),
        .i_b     (w_addend),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_beat) w_state_nxt = (i_len <= CNT_W'(1)) ? HOLD : ACCUM;
            ACCUM:   if (w_beat && r_rem == CNT_W'(1)) w_state_nxt = HOLD;
            HOLD:    if (i_out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = 1'b1;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            ACCUM:   o_busy = 1'b1;
            HOLD: begin
                o_in_ready  = 1'b0;
                o_out_valid = 1'b1;
                o_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Beats landing in an illegal state are swallowed; the FSM recovers to IDLE.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        w_rem_nxt = r_rem;
        if (w_beat) begin
            case (r_state)
                IDLE: begin
                    w_acc_nxt = w_addend;
                    w_ovf_nxt = 1'b0;
                    w_rem_nxt = (i_len == '0) ? '0 : i_len - CNT_W'(1);
                end
                ACCUM: begin
                    w_acc_nxt = w_sum;
                    w_ovf_nxt = r_ovf | w_carry;
                    w_rem_nxt = r_rem - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign w_done = (r_state != HOLD) && (w_state_nxt == HOLD);

    // Result registers are separate so a new block never disturbs the last total.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_rem     <= '0;
            r_out_acc <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
            r_rem <= w_rem_nxt;
            if (w_done) begin
                r_out_acc <= w_acc_nxt;
                r_out_ovf <= w_ovf_nxt;
            end
        end
    end

    assign o_out_acc = r_out_acc;
    assign o_out_ovf = r_out_ovf;
endmodule
